// File: rtl/ps2_kb_ctrl_if.sv
// Write/notify port from the PS/2 keyboard front end to the memory map and interrupt logic.
interface ps2_kb_ctrl_if;
  logic [31:0] kb_wraddr;
  logic [31:0] kb_wrdata;
  logic        kb_we;
  logic        irq_req;
  logic        frame_err;

  modport master (
    output kb_wraddr,
    output kb_wrdata,
    output kb_we,
    output irq_req,
    output frame_err
  );

  modport slave (
    input kb_wraddr,
    input kb_wrdata,
    input kb_we,
    input irq_req,
    input frame_err
  );
endinterface

// File: rtl/ps2_kb_ctrl.sv
// PS/2 keyboard receiver and scancode decoder: turns make/break/extended sequences into
// one 32-bit key-event word per key, written to the keyboard info register with an IRQ pulse.
module ps2_kb_ctrl #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [31:0] KB_INFO_ADDR   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ps2_clk_i,
  input  logic            ps2_data_i,
  ps2_kb_ctrl_if.master   kb_if
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TimeW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic [1:0]       clk_sync_q, data_sync_q;
  logic [FiltW-1:0] filt_cnt_q;
  logic             clk_filt_q;
  logic             filt_accept, fall, din;

  state_e           state_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shreg_q;
  logic             par_q;
  logic [TimeW-1:0] tmo_q;
  logic             shift_q, caps_q, brk_q, ext_q;
  logic [31:0]      wrdata_q;
  logic             we_q, ferr_q;

  logic             pressed, shift_nx, caps_nx;
  logic [7:0]       ascii;

  assign din         = data_sync_q[1];
  assign filt_accept = (clk_sync_q[1] != clk_filt_q) && (filt_cnt_q == FiltW'(FILTER_LEN - 1));
  assign fall        = filt_accept && !clk_sync_q[1];

  // Idle bus is high on both lines, so synchronizers and filter reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_cnt_q  <= '0;
      clk_filt_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      if (clk_sync_q[1] == clk_filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_accept) begin
        clk_filt_q <= clk_sync_q[1];
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + FiltW'(1);
      end
    end
  end

  function automatic logic [7:0] ascii_of(input logic [7:0] sc, input logic sh, input logic up);
    logic [7:0] lc;
    case (sc)
      8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
      8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
      8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
      8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
      8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
      8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
      8'h35: lc = "y";  8'h1A: lc = "z";
      default: lc = 8'h00;
    endcase
    if (lc != 8'h00) return up ? lc - 8'h20 : lc;
    case (sc)
      8'h16: return sh ? "!" : "1";
      8'h1E: return sh ? "@" : "2";
      8'h26: return sh ? "#" : "3";
      8'h25: return sh ? "$" : "4";
      8'h2E: return sh ? "%" : "5";
      8'h36: return sh ? "^" : "6";
      8'h3D: return sh ? "&" : "7";
      8'h3E: return sh ? "*" : "8";
      8'h46: return sh ? "(" : "9";
      8'h45: return sh ? ")" : "0";
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      default: return 8'h00;
    endcase
  endfunction

  // Event fields computed from the byte held in the shift register during the STOP cycle.
  always_comb begin
    pressed  = ~brk_q;
    shift_nx = shift_q;
    caps_nx  = caps_q;
    if (!ext_q && (shreg_q == 8'h12 || shreg_q == 8'h59)) shift_nx = pressed;
    if (!ext_q && shreg_q == 8'h58 && pressed) caps_nx = ~caps_q;
    ascii = ext_q ? 8'h00 : ascii_of(shreg_q, shift_nx, shift_nx ^ caps_nx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      shift_q   <= 1'b0;
      caps_q    <= 1'b0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      wrdata_q  <= '0;
      we_q      <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      ferr_q <= 1'b0;
      if (state_q != StIdle && !fall && tmo_q == TimeW'(TIMEOUT_CYCLES)) begin
        ferr_q  <= 1'b1;
        state_q <= StIdle;
        tmo_q   <= '0;
      end else begin
        if (state_q != StIdle) tmo_q <= fall ? '0 : tmo_q + TimeW'(1);
        if (fall) begin
          unique case (state_q)
            StIdle: begin
              if (!din) begin
                state_q   <= StData;
                bit_cnt_q <= '0;
                tmo_q     <= '0;
              end else begin
                ferr_q <= 1'b1;
              end
            end
            StData: begin
              shreg_q   <= {din, shreg_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) state_q <= StParity;
            end
            StParity: begin
              par_q   <= din;
              state_q <= StStop;
            end
            StStop: begin
              state_q <= StIdle;
              if (din && (^{shreg_q, par_q})) begin
                if (shreg_q == 8'hE0) begin
                  ext_q <= 1'b1;
                end else if (shreg_q == 8'hF0) begin
                  brk_q <= 1'b1;
                end else begin
                  shift_q  <= shift_nx;
                  caps_q   <= caps_nx;
                  wrdata_q <= {pressed, ext_q, shift_nx, caps_nx, 12'h000, ascii, shreg_q};
                  we_q     <= 1'b1;
                  brk_q    <= 1'b0;
                  ext_q    <= 1'b0;
                end
              end else begin
                ferr_q <= 1'b1;
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end
    end
  end

  assign kb_if.kb_wraddr = KB_INFO_ADDR;
  assign kb_if.kb_wrdata = wrdata_q;
  assign kb_if.kb_we     = we_q;
  assign kb_if.irq_req   = we_q;
  assign kb_if.frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_kb_ctrl.sv
// Bench for ps2_kb_ctrl: table of scancode frames with expected event words fed through a
// scoreboard queue, plus hand-written reset, error, timeout and glitch sequences.
module tb_ps2_kb_ctrl;
  localparam int unsigned Timeout = 5000;
  localparam int          H       = 16;  // clk cycles per PS/2 half-period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  always #5 clk = ~clk;

  ps2_kb_ctrl_if kb_if ();

  ps2_kb_ctrl #(
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(Timeout),
    .KB_INFO_ADDR  (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk_i (ps2_clk),
    .ps2_data_i(ps2_data),
    .kb_if     (kb_if)
  );

  typedef struct {
    logic [7:0]  code;
    bit          wr;
    logic [31:0] word;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] sb[$];
  logic [31:0] last_word = 32'h0;
  int          nvec = 0;
  int          nerr = 0;
  int          ferr_cnt = 0;
  logic        prev_we = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h, want %08h", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each write strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (kb_if.frame_err) ferr_cnt++;
      if (kb_if.kb_we) begin
        if (sb.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected write: got %08h, want no write", kb_if.kb_wrdata);
        end else begin
          check("event word", kb_if.kb_wrdata, sb.pop_front());
        end
        check("irq with we", 32'(kb_if.irq_req), 32'd1);
        check("wraddr", kb_if.kb_wraddr, 32'h0);
        check("we one cycle", 32'(prev_we), 32'd0);
      end
    end
    prev_we <= kb_if.kb_we;
  end

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      repeat (8) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (2) @(posedge clk);
      ps2_clk = 1'b1;
      repeat (H - 10) @(posedge clk);
    end else begin
      repeat (H) @(posedge clk);
    end
    ps2_clk = 1'b0;
    repeat (H) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                            input bit glitch);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i], glitch);
    ps2_data = 1'b1;
    repeat (3 * H) @(posedge clk);
  endtask

  task automatic expect_frame(input string name, input logic [7:0] b, input bit wr,
                              input logic [31:0] word, input bit glitch);
    if (wr) begin
      sb.push_back(word);
      last_word = word;
    end
    send_frame(b, 1'b0, 11, glitch);
    check({name, " drained"}, 32'(sb.size()), 32'd0);
    check({name, " held"}, kb_if.kb_wrdata, last_word);
  endtask

  task automatic add(input logic [7:0] c, input bit wr, input logic [31:0] w);
    vec_t v;
    v.code = c;
    v.wr   = wr;
    v.word = w;
    tbl.push_back(v);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    add(8'h12, 1, 32'hA000_0012); add(8'h1C, 1, 32'hA000_411C);
    add(8'hF0, 0, 0);             add(8'h12, 1, 32'h0000_0012);
    add(8'hF0, 0, 0);             add(8'h1C, 1, 32'h0000_611C);
    add(8'h58, 1, 32'h9000_0058); add(8'hF0, 0, 0);
    add(8'h58, 1, 32'h1000_0058); add(8'h16, 1, 32'h9000_3116);
    add(8'h1C, 1, 32'h9000_411C); add(8'h12, 1, 32'hB000_0012);
    add(8'h16, 1, 32'hB000_2116); add(8'h1C, 1, 32'hB000_611C);
    add(8'hF0, 0, 0);             add(8'h12, 1, 32'h1000_0012);
    add(8'h58, 1, 32'h8000_0058); add(8'hF0, 0, 0);
    add(8'h58, 1, 32'h0000_0058);
    add(8'hE0, 0, 0);             add(8'h75, 1, 32'hC000_0075);
    add(8'hE0, 0, 0);             add(8'hF0, 0, 0);
    add(8'h75, 1, 32'h4000_0075);
    add(8'hF0, 0, 0);             add(8'hE0, 0, 0);
    add(8'h75, 1, 32'h4000_0075);
    add(8'hE0, 0, 0);             add(8'h12, 1, 32'hC000_0012);
    add(8'h1C, 1, 32'h8000_611C); add(8'h5A, 1, 32'h8000_0D5A);
    add(8'h66, 1, 32'h8000_0866); add(8'h45, 1, 32'h8000_3045);
    add(8'h0E, 1, 32'h8000_000E);
    add(8'h59, 1, 32'hA000_0059); add(8'h45, 1, 32'hA000_2945);
    add(8'h2E, 1, 32'hA000_252E); add(8'hF0, 0, 0);
    add(8'h59, 1, 32'h0000_0059);

    // Reset values
    repeat (5) @(posedge clk);
    #1;
    check("reset wrdata", kb_if.kb_wrdata, 32'h0);
    check("reset we", 32'(kb_if.kb_we), 32'd0);
    check("reset irq", 32'(kb_if.irq_req), 32'd0);
    check("reset ferr", 32'(kb_if.frame_err), 32'd0);
    @(posedge clk);
    rst_n = 1'b1;

    // Reset in the middle of DATA discards the partial frame
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    rst_n = 1'b0;
    ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    rst_n = 1'b1;
    repeat (3 * H) @(posedge clk);
    f0 = ferr_cnt;
    expect_frame("post-reset 1C", 8'h1C, 1, 32'h8000_611C, 1'b0);
    check("post-reset no ferr", 32'(ferr_cnt - f0), 32'd0);

    foreach (tbl[i])
      expect_frame($sformatf("vec%0d %02h", i, tbl[i].code), tbl[i].code, tbl[i].wr,
                   tbl[i].word, 1'b0);

    // Parity error
    f0 = ferr_cnt;
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    check("parity ferr", 32'(ferr_cnt - f0), 32'd1);
    check("parity no write", 32'(sb.size()), 32'd0);
    check("parity held", kb_if.kb_wrdata, last_word);

    // Start bit high in IDLE
    f0 = ferr_cnt;
    ps2_bit(1'b1, 1'b0);
    repeat (3 * H) @(posedge clk);
    check("start ferr", 32'(ferr_cnt - f0), 32'd1);

    // Timeout after 5 bits, then a clean frame
    f0 = ferr_cnt;
    send_frame(8'h29, 1'b0, 5, 1'b0);
    check("no early timeout", 32'(ferr_cnt - f0), 32'd0);
    repeat (Timeout + 50) @(posedge clk);
    check("timeout ferr", 32'(ferr_cnt - f0), 32'd1);
    expect_frame("after timeout 29", 8'h29, 1, 32'h8000_2029, 1'b0);

    // Short clock glitches during frames are filtered out
    f0 = ferr_cnt;
    expect_frame("glitch 1C", 8'h1C, 1, 32'h8000_611C, 1'b1);
    expect_frame("glitch 16", 8'h16, 1, 32'h8000_3116, 1'b1);
    check("glitch no ferr", 32'(ferr_cnt - f0), 32'd0);
    check("irq idle", 32'(kb_if.irq_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
